// File: rtl/seg7_count_display_pkg.sv
// rtl/seg7_count_display_pkg.sv - shared segment codes and scan-state encodings for the 7-segment display blocks
package seg7_count_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit scan states; the encoding doubles as the digit index
    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } scan_state_t;

endpackage

// File: rtl/seg7_count_display_hex_to_seg7.sv
// rtl/seg7_count_display_hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_seg7
    import seg7_count_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Map each hex value onto its glyph; lowercase b and d keep them distinct from 8 and 0
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_count_display.sv
// rtl/seg7_count_display.sv - counter nibble + carry-wrap count on a 4-digit multiplexed display; SEG7_OVERFLOW_DP_EN adds a sticky overflow dp
module seg7_count_display
    import seg7_count_display_pkg::*;
#(
    parameter int SCAN_DIV = 16,
    parameter int WRAP_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        q,
    input  logic              rc,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [3:0]          q_in_q, q_in_d;
    logic                rc_in_q, rc_in_d;
    logic                rc_prev_q, rc_prev_d;
    logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
    logic [15:0]         div_q, div_d;
    scan_state_t         state_q, state_d;
    logic [WRAP_W+3:0]   snap_q, snap_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                wrap_pulse;
    logic                tick;
    logic                frame_tick;
    logic [3:0]          digit;
    logic [6:0]          seg_code;

    // Input capture, wrap counting, scan divider, scan FSM and frame snapshot
    always_comb begin
        q_in_d     = q;
        rc_in_d    = rc;
        rc_prev_d  = rc_in_q;
        wrap_pulse = rc_in_q & ~rc_prev_q;
        wrap_cnt_d = wrap_pulse ? wrap_cnt_q + 1'b1 : wrap_cnt_q;
        tick       = (div_q == DIV_LAST);
        div_d      = tick ? 16'd0 : div_q + 16'd1;
        frame_tick = tick && (state_q == D3);
        state_d    = state_q;
        snap_d     = snap_q;
        if (tick) begin
            case (state_q)
                D0:      state_d = D1;
                D1:      state_d = D2;
                D2:      state_d = D3;
                default: state_d = D0;
            endcase
        end
        // Register value is pre-increment, so a same-cycle wrap lands in the next frame
        if (frame_tick) begin
            snap_d = {wrap_cnt_q, q_in_q};
        end
    end

    // Select the active digit's nibble from the frozen frame and its anode enable
    always_comb begin
        digit = snap_q[3:0];
        an_d  = 4'b1110;
        case (state_q)
            D0: begin digit = snap_q[3:0];   an_d = 4'b1110; end
            D1: begin digit = snap_q[7:4];   an_d = 4'b1101; end
            D2: begin digit = snap_q[11:8];  an_d = 4'b1011; end
            D3: begin digit = snap_q[15:12]; an_d = 4'b0111; end
            default: begin digit = snap_q[3:0]; an_d = 4'b1110; end
        endcase
        seg_d = seg_code;
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (digit),
        .seg    (seg_code)
    );

    // State and output registers; outputs blank immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_in_q     <= 4'd0;
            rc_in_q    <= 1'b0;
            rc_prev_q  <= 1'b0;
            wrap_cnt_q <= '0;
            div_q      <= 16'd0;
            state_q    <= D0;
            snap_q     <= '0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_BLANK;
        end else begin
            q_in_q     <= q_in_d;
            rc_in_q    <= rc_in_d;
            rc_prev_q  <= rc_prev_d;
            wrap_cnt_q <= wrap_cnt_d;
            div_q      <= div_d;
            state_q    <= state_d;
            snap_q     <= snap_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
    assign an       = an_q;
    assign seg      = seg_q;

`ifdef SEG7_OVERFLOW_DP_EN
    logic ovf_q, ovf_d;
    logic snap_ovf_q, snap_ovf_d;
    logic dp_q, dp_d;

    // Sticky overflow on FFF->000 roll, frozen per frame, lit on the most significant digit
    always_comb begin
        ovf_d      = ovf_q | (wrap_pulse & (wrap_cnt_q == '1));
        snap_ovf_d = frame_tick ? ovf_q : snap_ovf_q;
        dp_d       = ~((state_q == D3) & snap_ovf_q);
    end

    // Overflow and decimal-point registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            snap_ovf_q <= 1'b0;
            dp_q       <= 1'b1;
        end else begin
            ovf_q      <= ovf_d;
            snap_ovf_q <= snap_ovf_d;
            dp_q       <= dp_d;
        end
    end

    assign dp = dp_q;
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_count_display.sv
// tb/tb_seg7_count_display.sv - directed self-checking bench for seg7_count_display with SCAN_DIV=4
module tb_seg7_count_display;

    localparam int SCAN_DIV = 4;

    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_3     = 7'b0110000;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_A     = 7'b0001000;
    localparam logic [6:0] S_BLANK = 7'b1111111;

`ifdef SEG7_OVERFLOW_DP_EN
    localparam logic EXP_DP_OVF = 1'b0;
`else
    localparam logic EXP_DP_OVF = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  q   = 4'd0;
    logic        rc  = 1'b0;
    logic [11:0] wrap_cnt;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg7_count_display #(
        .SCAN_DIV (SCAN_DIV),
        .WRAP_W   (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .q        (q),
        .rc       (rc),
        .wrap_cnt (wrap_cnt),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rc();
        rc = 1'b1;
        step(1);
        rc = 1'b0;
        step(1);
    endtask

    // Returns at the first output cycle of a new frame (an just went 0111 -> 1110)
    task automatic wait_frame();
        logic [3:0] prev;
        bit         found;
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (prev == 4'b0111 && an == 4'b1110) found = 1'b1;
            prev = an;
        end
        check("frame_sync", {15'd0, found}, 16'd1);
    endtask

    initial begin
        logic [3:0] exp_an;

        // Reset state
        step(3);
        check("rst_an", {12'd0, an}, {12'd0, 4'b1111});
        check("rst_seg", {9'd0, seg}, {9'd0, S_BLANK});
        check("rst_dp", {15'd0, dp}, 16'd1);
        check("rst_wrap", {4'd0, wrap_cnt}, 16'd0);

        // Scan order over the first frame
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step(1);
            exp_an = 4'b1111 ^ (4'b0001 << (c / 4));
            check("scan_an", {12'd0, an}, {12'd0, exp_an});
            check("scan_seg", {9'd0, seg}, {9'd0, S_0});
        end
        step(1);
        check("scan_repeat", {12'd0, an}, {12'd0, 4'b1110});

        // Carry counting: three full counter periods
        for (int i = 0; i < 48; i++) begin
            q  = 4'(i % 16);
            rc = ((i % 16) == 15);
            step(1);
        end
        q  = 4'd0;
        rc = 1'b0;
        step(2);
        check("wrap_three", {4'd0, wrap_cnt}, 16'd3);
        wait_frame();
        check("carry_d0", {9'd0, seg}, {9'd0, S_0});
        step(4);
        check("carry_an1", {12'd0, an}, {12'd0, 4'b1101});
        check("carry_d1", {9'd0, seg}, {9'd0, S_3});
        step(4);
        check("carry_d2", {9'd0, seg}, {9'd0, S_0});
        step(4);
        check("carry_an3", {12'd0, an}, {12'd0, 4'b0111});
        check("carry_d3", {9'd0, seg}, {9'd0, S_0});
        check("carry_dp", {15'd0, dp}, 16'd1);

        // Stuck carry counts once
        rc = 1'b1;
        step(10);
        rc = 1'b0;
        step(3);
        check("stuck_rc", {4'd0, wrap_cnt}, 16'd4);

        // Snapshot stability
        q = 4'hA;
        step(2);
        wait_frame();
        check("snap_a_start", {9'd0, seg}, {9'd0, S_A});
        q = 4'h5;
        step(2);
        check("snap_a_hold", {9'd0, seg}, {9'd0, S_A});
        wait_frame();
        check("snap_5_next", {9'd0, seg}, {9'd0, S_5});

        // Rollover of the wrap counter
        repeat (4091) pulse_rc();
        check("wrap_fff", {4'd0, wrap_cnt}, 16'h0FFF);
        pulse_rc();
        check("wrap_000", {4'd0, wrap_cnt}, 16'h0000);
        wait_frame();
        step(12);
        check("ovf_an3", {12'd0, an}, {12'd0, 4'b0111});
        check("ovf_dp_d3", {15'd0, dp}, {15'd0, EXP_DP_OVF});
        step(4);
        check("ovf_dp_d0", {15'd0, dp}, 16'd1);
        step(12);
        check("ovf_dp_d3_again", {15'd0, dp}, {15'd0, EXP_DP_OVF});

        // Asynchronous reset mid-D2
        wait_frame();
        step(9);
        check("pre_rst_an", {12'd0, an}, {12'd0, 4'b1011});
        #2;
        rst = 1'b1;
        #1;
        check("async_an", {12'd0, an}, {12'd0, 4'b1111});
        check("async_seg", {9'd0, seg}, {9'd0, S_BLANK});
        check("async_wrap", {4'd0, wrap_cnt}, 16'd0);
        check("async_dp", {15'd0, dp}, 16'd1);
        step(1);
        rst = 1'b0;
        step(1);
        check("restart_an", {12'd0, an}, {12'd0, 4'b1110});
        check("restart_seg", {9'd0, seg}, {9'd0, S_0});
        step(4);
        check("restart_d1", {9'd0, seg}, {9'd0, S_0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
